// File: rtl/serial_eq_ctrl.sv
// Bit-serial equality comparator that drives an external 1-bit eq cell LSB first.
// Optional build macro SERIAL_EQ_EARLY_EXIT_EN: finish in the cycle after the first mismatching bit.
module serial_eq_ctrl #(
  parameter int unsigned WIDTH = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic [WIDTH-1:0]           a,
  input  logic [WIDTH-1:0]           b,
  output logic                       bit_i1,
  output logic                       bit_i2,
  input  logic                       bit_eq,
  output logic                       busy,
  output logic                       done,
  output logic                       equal,
  output logic [$clog2(WIDTH)-1:0]   mismatch_idx
);

  localparam int unsigned IDXW = $clog2(WIDTH);

`ifdef SERIAL_EQ_EARLY_EXIT_EN
  localparam bit EARLY_EXIT = 1'b1;
`else
  localparam bit EARLY_EXIT = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t            state, state_nxt;
  logic [WIDTH-1:0]  sh_a, sh_b;
  logic [IDXW-1:0]   cnt;
  logic              acc;
  logic              equal_q;
  logic [IDXW-1:0]   idx_q;

  logic load_c, step_c, finish_c, last_c, miss_c;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state and datapath control
  always_comb begin
    state_nxt = state;
    load_c    = 1'b0;
    step_c    = 1'b0;
    finish_c  = 1'b0;
    last_c    = (cnt == IDXW'(WIDTH - 1));
    miss_c    = acc & ~bit_eq;
    case (state)
      IDLE, DONE: begin
        if (start) begin
          load_c    = 1'b1;
          state_nxt = RUN;
        end else begin
          state_nxt = IDLE;
        end
      end
      RUN: begin
        step_c = 1'b1;
        if (last_c || (EARLY_EXIT && !bit_eq)) begin
          finish_c  = 1'b1;
          state_nxt = DONE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Operand shifters, bit counter, accumulator and result capture
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_a    <= '0;
      sh_b    <= '0;
      cnt     <= '0;
      acc     <= 1'b0;
      equal_q <= 1'b0;
      idx_q   <= '0;
    end else if (load_c) begin
      sh_a    <= a;
      sh_b    <= b;
      cnt     <= '0;
      acc     <= 1'b1;
      equal_q <= 1'b0;
      idx_q   <= '0;
    end else if (step_c) begin
      sh_a <= sh_a >> 1;
      sh_b <= sh_b >> 1;
      if (!last_c) cnt <= cnt + IDXW'(1);
      acc <= acc & bit_eq;
      // Only the first mismatch is recorded: acc is still 1 up to that bit.
      if (miss_c)   idx_q   <= cnt;
      if (finish_c) equal_q <= acc & bit_eq;
    end
  end

  assign busy         = (state == RUN);
  assign done         = (state == DONE);
  assign bit_i1       = busy & sh_a[0];
  assign bit_i2       = busy & sh_b[0];
  assign equal        = equal_q;
  assign mismatch_idx = idx_q;

endmodule

// File: tb/tb_serial_eq_ctrl.sv
// Directed self-checking bench for serial_eq_ctrl (WIDTH=8) with a behavioural 1-bit eq cell.
module tb_serial_eq_ctrl;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned IDXW  = 3;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic [WIDTH-1:0] a = '0;
  logic [WIDTH-1:0] b = '0;
  logic             bit_i1, bit_i2, bit_eq;
  logic             busy, done, equal;
  logic [IDXW-1:0]  mismatch_idx;

  int n_chk  = 0;
  int n_fail = 0;

  serial_eq_ctrl #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b),
    .bit_i1(bit_i1), .bit_i2(bit_i2), .bit_eq(bit_eq),
    .busy(busy), .done(done), .equal(equal), .mismatch_idx(mismatch_idx)
  );

  assign bit_eq = ~(bit_i1 ^ bit_i2);

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       exp_equal;
    logic [2:0] exp_idx;
    int         lat_early;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int exp_lat(input int lat_early);
`ifdef SERIAL_EQ_EARLY_EXIT_EN
    return lat_early;
`else
    return 8;
`endif
  endfunction

  // From a negedge sample point: count busy cycles until done, checking the serialized bits.
  task automatic run_until_done(input logic [7:0] ea, input logic [7:0] eb, input int lat0,
                                output int lat, output bit seen, output bit bits_ok);
    lat = lat0; seen = 1'b0; bits_ok = 1'b1;
    for (int i = 0; i < 40; i++) begin
      if (done) begin
        seen = 1'b1;
        if (bit_i1 !== 1'b0 || bit_i2 !== 1'b0 || busy !== 1'b0) bits_ok = 1'b0;
        break;
      end
      if (busy) begin
        if (lat < 8 && (bit_i1 !== ea[lat] || bit_i2 !== eb[lat])) bits_ok = 1'b0;
        lat++;
      end else if (bit_i1 !== 1'b0 || bit_i2 !== 1'b0) begin
        bits_ok = 1'b0;
      end
      @(negedge clk);
    end
  endtask

  task automatic issue(input logic [7:0] va, input logic [7:0] vb);
    a = va; b = vb; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  vec_t vecs[8];
  int   lat;
  bit   seen, bits_ok;

  initial begin
    vecs[0] = '{8'hA5, 8'hA5, 1'b1, 3'd0, 8};
    vecs[1] = '{8'hA5, 8'h25, 1'b0, 3'd7, 8};
    vecs[2] = '{8'h0F, 8'h0B, 1'b0, 3'd2, 3};
    vecs[3] = '{8'hFF, 8'h00, 1'b0, 3'd0, 1};
    vecs[4] = '{8'h00, 8'h00, 1'b1, 3'd0, 8};
    vecs[5] = '{8'h3C, 8'h34, 1'b0, 3'd3, 4};
    vecs[6] = '{8'h80, 8'h00, 1'b0, 3'd7, 8};
    vecs[7] = '{8'h55, 8'hAA, 1'b0, 3'd0, 1};

    // Reset state
    repeat (2) @(negedge clk);
    chk("reset_outputs", {26'd0, busy, done, equal, bit_i1, bit_i2, 1'b0}, 32'd0);
    chk("reset_idx", 32'(mismatch_idx), 32'd0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("post_reset_no_done", {30'd0, done, busy}, 32'd0);

    // Table-driven compares
    foreach (vecs[k]) begin
      issue(vecs[k].a, vecs[k].b);
      run_until_done(vecs[k].a, vecs[k].b, 0, lat, seen, bits_ok);
      chk($sformatf("v%0d_done_seen", k), 32'(seen), 32'd1);
      chk($sformatf("v%0d_latency", k), 32'(lat), 32'(exp_lat(vecs[k].lat_early)));
      chk($sformatf("v%0d_equal", k), 32'(equal), 32'(vecs[k].exp_equal));
      chk($sformatf("v%0d_idx", k), 32'(mismatch_idx), 32'(vecs[k].exp_idx));
      chk($sformatf("v%0d_bits", k), 32'(bits_ok), 32'd1);
      @(negedge clk);
      chk($sformatf("v%0d_done_pulse", k), {29'd0, done, bit_i1, bit_i2}, 32'd0);
      chk($sformatf("v%0d_equal_held", k), 32'(equal), 32'(vecs[k].exp_equal));
    end

    // Start during RUN is ignored
    issue(8'hA5, 8'hA5);
    a = 8'h00; b = 8'hFF; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    run_until_done(8'hA5, 8'hA5, 1, lat, seen, bits_ok);
    chk("ignore_done_seen", 32'(seen), 32'd1);
    chk("ignore_latency", 32'(lat), 32'd8);
    chk("ignore_equal", 32'(equal), 32'd1);
    chk("ignore_bits", 32'(bits_ok), 32'd1);

    // Start accepted in the DONE cycle
    a = 8'hFF; b = 8'hFF; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("restart_busy", {30'd0, busy, done}, 32'd2);
    chk("restart_equal_cleared", 32'(equal), 32'd0);
    run_until_done(8'hFF, 8'hFF, 0, lat, seen, bits_ok);
    chk("restart_latency", 32'(lat), 32'd8);
    chk("restart_equal", 32'(equal), 32'd1);
    @(negedge clk);

    // Reset in RUN cycle 4
    issue(8'hA5, 8'h25);
    repeat (3) @(negedge clk);
    chk("pre_reset_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("midrun_reset_outputs", {27'd0, busy, done, equal, bit_i1, bit_i2}, 32'd0);
    chk("midrun_reset_idx", 32'(mismatch_idx), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done || busy) seen = 1'b1;
    end
    chk("post_reset_quiet", 32'(seen), 32'd0);
    issue(8'hFF, 8'h00);
    run_until_done(8'hFF, 8'h00, 0, lat, seen, bits_ok);
    chk("fresh_done_seen", 32'(seen), 32'd1);
    chk("fresh_latency", 32'(lat), 32'(exp_lat(1)));
    chk("fresh_equal", 32'(equal), 32'd0);
    chk("fresh_idx", 32'(mismatch_idx), 32'd0);
    chk("fresh_bits", 32'(bits_ok), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/serial_eq_ctrl.md
SERIAL_EQ_CTRL -- requirements
Module: serial_eq_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 8, meaning operand width in bits; legal range 2..32.
REQ-002 SHALL have localparam IDXW = clog2(WIDTH), meaning bit-index width.
REQ-003 SHALL have port clk  input  1  meaning the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n  input  1  meaning the reset, asynchronous assert and active-low.
REQ-005 SHALL have port start  input  1  meaning a request to compare a and b.
REQ-006 SHALL have port a  input  WIDTH  meaning the first operand, sampled only when start is accepted.
REQ-007 SHALL have port b  input  WIDTH  meaning the second operand, sampled only when start is accepted.
REQ-008 SHALL have port bit_i1  output  1  meaning the current a bit, driven to the external 1-bit eq cell i1.
REQ-009 SHALL have port bit_i2  output  1  meaning the current b bit, driven to the external 1-bit eq cell i2.
REQ-010 SHALL have port bit_eq  input  1  meaning the eq cell result for the current bit, used combinationally in the same cycle.
REQ-011 SHALL have port busy  output  1  meaning high while in RUN.
REQ-012 SHALL have port done  output  1  meaning a one-cycle pulse: result valid.
REQ-013 SHALL have port equal  output  1  meaning 1 when all compared bits matched; held until the next start is accepted.
REQ-014 SHALL have port mismatch_idx  output  IDXW  meaning the index of the lowest mismatching bit; 0 when equal=1.

Function
REQ-015 SHALL implement an FSM with states IDLE, RUN and DONE.
REQ-016 SHALL accept start in IDLE or DONE: it loads a and b into shift registers, clears the bit counter to 0, sets the accumulator to 1, clears equal and mismatch_idx, and enters RUN.
REQ-017 SHALL ignore start while in RUN, with no effect on state or operands.
REQ-018 SHALL, in RUN, drive bit_i1 and bit_i2 with bit[counter] of the captured operands, LSB first, one bit per cycle.
REQ-019 SHALL, in RUN, AND bit_eq into the accumulator each cycle and, on the first cycle bit_eq=0, record counter into mismatch_idx.
REQ-020 SHALL go from RUN to DONE after the cycle where counter = WIDTH-1, so compare latency = WIDTH RUN cycles.
REQ-021 SHALL assert done for exactly the one DONE cycle, with equal and mismatch_idx final in that cycle; DONE goes to IDLE unless start is accepted.
REQ-022 SHALL drive bit_i1 = bit_i2 = 0 outside RUN.
REQ-023 SHALL keep the counter from wrapping; counter stays in 0..WIDTH-1.

Reset
REQ-024 SHALL, on rst_n low at any time including mid-RUN, go to IDLE immediately and zero busy, done, equal, mismatch_idx, the counter and the shift registers.
REQ-025 SHALL, after rst_n deasserts, produce no done until a new start is accepted.

Configuration
REQ-026 SHALL, with SERIAL_EQ_EARLY_EXIT_EN defined, go from RUN to DONE in the cycle after the first bit_eq=0, so a mismatch at bit j gives done after j+1 RUN cycles.
REQ-027 SHALL, without SERIAL_EQ_EARLY_EXIT_EN, always run all WIDTH cycles; equal and mismatch_idx are identical in both builds.

Verification (WIDTH=8, bench models eq cell as bit_eq = ~(bit_i1^bit_i2))
REQ-028 a=8'hA5, b=8'hA5, start pulse -> busy for 8 cycles, done pulse, equal=1, mismatch_idx=0.
REQ-029 a=8'hA5, b=8'h25 -> equal=0, mismatch_idx=7, done after 8 RUN cycles in both builds.
REQ-030 a=8'h0F, b=8'h0B, early exit on -> done after 3 RUN cycles, equal=0, mismatch_idx=2; early exit off -> 8 cycles, same result.
REQ-031 start re-pulsed with new operands during RUN -> ignored; result matches the first operands; start in the DONE cycle -> new compare begins next cycle.
REQ-032 rst_n low at RUN cycle 4 -> all outputs 0 the same cycle, no done; a fresh start then completes normally.
REQ-033 a=8'hFF, b=8'h00 -> mismatch_idx=0, equal=0; bit_i1 and bit_i2 stay 0 in IDLE and DONE throughout.
